// File: rtl/step_clock_pkg.sv
// Shared types for the step clock generator.
// Mode encodings match the Mode input pins.
package step_clock_pkg;
  localparam int STEP_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    BURST = 2'b10
  } state_t;
endpackage

// File: rtl/step_clock_gen_key_debounce.sv
// One active-low key: 2-flop synchroniser, then a stability
// counter that must see DEBOUNCE_CYCLES differing samples in a row.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyN,
  output logic Level,
  output logic Press
);
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          w_raw;

  assign w_raw = ~r_s2;
  assign Level = r_level;
  assign Press = r_press;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= KeyN;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (w_raw == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= w_raw;
        r_press <= w_raw;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/step_clock_gen.sv
// Key front end plus processor step-enable generator with
// manual, free-run, burst and hold modes.
module step_clock_gen
  import step_clock_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_KEY        = 2,
  parameter int RATE_W          = 24,
  parameter int BURST_W         = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NUM_KEYS-1:0]   KeyN,
  input  logic [1:0]            Mode,
  input  logic [RATE_W-1:0]     RateDiv,
  input  logic [BURST_W-1:0]    BurstLen,
  input  logic                  ClearCount,
  output logic [NUM_KEYS-1:0]   KeyLevel,
  output logic [NUM_KEYS-1:0]   KeyPress,
  output logic                  StepEn,
  output logic                  Busy,
  output logic [STEP_CNT_W-1:0] StepCount
);
  logic [NUM_KEYS-1:0]   w_level;
  logic [NUM_KEYS-1:0]   w_press;
  mode_t                 w_mode;
  logic                  w_go;
  logic                  w_tc;

  state_t                r_state;
  logic [RATE_W-1:0]     r_rate;
  logic [BURST_W-1:0]    r_rem;
  logic                  r_step;
  logic                  r_busy;
  logic [STEP_CNT_W-1:0] r_count;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .Clock(Clock),
      .Reset(Reset),
      .KeyN (KeyN[g]),
      .Level(w_level[g]),
      .Press(w_press[g])
    );
  end

  assign KeyLevel  = w_level;
  assign KeyPress  = w_press;
  assign StepEn    = r_step;
  assign Busy      = r_busy;
  assign StepCount = r_count;

  assign w_mode = mode_t'(Mode);
  assign w_go   = w_press[STEP_KEY];
  // >= so a live RateDiv lowered below the count still terminates
  assign w_tc   = (r_rate >= RateDiv);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_rate  <= '0;
      r_rem   <= '0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_rate <= '0;
          if (w_go) begin
            unique case (w_mode)
              MODE_MANUAL: r_step <= 1'b1;
              MODE_RUN: begin
                r_state <= RUN;
                r_busy  <= 1'b1;
              end
              MODE_BURST: begin
                if (BurstLen != '0) begin
                  r_state <= BURST;
                  r_busy  <= 1'b1;
                  r_rem   <= BurstLen;
                end
              end
              MODE_HOLD: ;
            endcase
          end
        end
        RUN: begin
          if (w_go || w_mode != MODE_RUN) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_tc) begin
            r_step <= 1'b1;
            r_rate <= '0;
          end else begin
            r_rate <= r_rate + 1'b1;
          end
        end
        BURST: begin
          if (w_go || w_mode != MODE_BURST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_tc) begin
            r_step <= 1'b1;
            r_rate <= '0;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == BURST_W'(1)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_rate <= r_rate + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (ClearCount) begin
      r_count <= '0;
    end else if (r_step) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule
